ins_prefetch_queue: RTL and testbench

- Parametrised successor to the single instruction register of the multi-cycle CPU.
- Buffers up to DEPTH fetched instructions, each with its PC, between instruction memory and the control unit.
- Presents the head instruction already split into MIPS fields.
- Valid/ready handshakes on both sides plus a flush for taken branches and jumps. Sits between the PC/IMEM fetch stage and ControlUnit/RegFile.

---
 rtl/ins_prefetch_queue_pkg.sv | 17 +
 rtl/ins_prefetch_queue_if.sv | 32 +++
 rtl/ins_prefetch_queue_field_decode.sv | 19 +
 rtl/ins_prefetch_queue.sv | 59 +++++
 tb/tb_ins_prefetch_queue.sv | 130 +++++++++++++
 5 files changed

// File: rtl/ins_prefetch_queue_pkg.sv
// cpu_defs: MIPS instruction field positions and default datapath widths
package cpu_defs;
    localparam int DEF_INS_W = 32;
    localparam int DEF_PC_W  = 32;
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int RS_HI   = 25;
    localparam int RS_LO   = 21;
    localparam int RT_HI   = 20;
    localparam int RT_LO   = 16;
    localparam int RD_HI   = 15;
    localparam int RD_LO   = 11;
    localparam int SA_HI   = 10;
    localparam int SA_LO   = 6;
    localparam int IMM_HI  = 15;
    localparam int ADDR_HI = 25;
endpackage

// File: rtl/ins_prefetch_queue_if.sv
// ins_prefetch_queue_if: fetch-side and consumer-side handshakes of the prefetch queue
interface ins_prefetch_queue_if import cpu_defs::*; #(
    parameter int INS_W = DEF_INS_W,
    parameter int PC_W  = DEF_PC_W,
    parameter int CNT_W = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [INS_W-1:0] in_ins;
    logic [PC_W-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [INS_W-1:0] out_ins;
    logic [PC_W-1:0]  out_pc;
    logic [5:0]       opCode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       sa;
    logic [15:0]      immediate;
    logic [25:0]      addr;
    logic [CNT_W-1:0] count;
    modport master (
        output flush, in_valid, in_ins, in_pc, out_ready,
        input  in_ready, out_valid, out_ins, out_pc, opCode, rs, rt, rd, sa, immediate, addr, count
    );
    modport slave (
        input  flush, in_valid, in_ins, in_pc, out_ready,
        output in_ready, out_valid, out_ins, out_pc, opCode, rs, rt, rd, sa, immediate, addr, count
    );
endinterface

// File: rtl/ins_prefetch_queue_field_decode.sv
// ins_field_decode: combinational split of a 32-bit MIPS word into its fields
module ins_field_decode import cpu_defs::*; (
    input  logic [31:0] ins,
    output logic [5:0]  opCode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  sa,
    output logic [15:0] immediate,
    output logic [25:0] addr
);
    assign opCode    = ins[OP_HI:OP_LO];
    assign rs        = ins[RS_HI:RS_LO];
    assign rt        = ins[RT_HI:RT_LO];
    assign rd        = ins[RD_HI:RD_LO];
    assign sa        = ins[SA_HI:SA_LO];
    assign immediate = ins[IMM_HI:0];
    assign addr      = ins[ADDR_HI:0];
endmodule

// File: rtl/ins_prefetch_queue.sv
// ins_prefetch_queue: circular buffer of fetched {ins, pc} entries with a pre-decoded head
module ins_prefetch_queue import cpu_defs::*; #(
    parameter int INS_W = DEF_INS_W,
    parameter int PC_W  = DEF_PC_W,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input logic CLK,
    input logic Reset,
    ins_prefetch_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push, pop;
    // in_ready deliberately ignores a concurrent pop: no bypass when full
    assign q.in_ready  = cnt != CNT_W'(DEPTH);
    assign q.out_valid = cnt != '0;
    assign q.count     = cnt;
    assign q.out_ins   = ins_mem[rd_ptr];
    assign q.out_pc    = pc_mem[rd_ptr];
    assign push = q.in_valid & q.in_ready;
    assign pop  = q.out_valid & q.out_ready;
    ins_field_decode u_dec (
        .ins       (ins_mem[rd_ptr]),
        .opCode    (q.opCode),
        .rs        (q.rs),
        .rt        (q.rt),
        .rd        (q.rd),
        .sa        (q.sa),
        .immediate (q.immediate),
        .addr      (q.addr)
    );
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ins_mem[i] <= '0;
                pc_mem[i]  <= '0;
            end
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                ins_mem[wr_ptr] <= q.in_ins;
                pc_mem[wr_ptr]  <= q.in_pc;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end
endmodule

// File: tb/tb_ins_prefetch_queue.sv
// tb_ins_prefetch_queue: directed vector table plus hand sequences for wrap, flush, reset and decode
module tb_ins_prefetch_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    ins_prefetch_queue_if #(.INS_W(32), .PC_W(32), .CNT_W(3)) bus ();
    ins_prefetch_queue #(.INS_W(32), .PC_W(32), .DEPTH(4), .CNT_W(3)) dut (
        .CLK   (clk),
        .Reset (rst_n),
        .q     (bus)
    );
    typedef struct {
        logic        rstn, flush, push, pop;
        logic [31:0] ins, pc;
        logic [2:0]  cnt;
        logic        ov, ir;
        logic [31:0] hins, hpc;
    } vec_t;
    vec_t tv [16];
    logic [31:0] mq_ins [$];
    logic [31:0] mq_pc [$];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic step(input logic rn, input logic f, input logic p, input logic r,
                        input logic [31:0] ins, input logic [31:0] pc);
        rst_n         = rn;
        bus.flush     = f;
        bus.in_valid  = p;
        bus.out_ready = r;
        bus.in_ins    = ins;
        bus.in_pc     = pc;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask
    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 0; bus.in_ins = 0; bus.in_pc = 0;
        //          rstn f  p  r  ins           pc     cnt ov ir hins          hpc
        tv[0]  = '{0, 0, 0, 0, 32'h0,        32'h0,  0, 0, 1, 32'h0,        32'h0};
        tv[1]  = '{1, 0, 1, 0, 32'h8C220004, 32'h0,  1, 1, 1, 32'h8C220004, 32'h0};
        tv[2]  = '{1, 0, 0, 1, 32'h0,        32'h0,  0, 0, 1, 32'h0,        32'h0};
        tv[3]  = '{1, 1, 0, 0, 32'h0,        32'h0,  0, 0, 1, 32'h8C220004, 32'h0};
        tv[4]  = '{1, 0, 1, 0, 32'h1,        32'h0,  1, 1, 1, 32'h1,        32'h0};
        tv[5]  = '{1, 0, 1, 0, 32'h2,        32'h4,  2, 1, 1, 32'h1,        32'h0};
        tv[6]  = '{1, 0, 1, 0, 32'h3,        32'h8,  3, 1, 1, 32'h1,        32'h0};
        tv[7]  = '{1, 0, 1, 0, 32'h4,        32'hC,  4, 1, 0, 32'h1,        32'h0};
        tv[8]  = '{1, 0, 1, 0, 32'h5,        32'h10, 4, 1, 0, 32'h1,        32'h0};
        tv[9]  = '{1, 0, 1, 1, 32'h6,        32'h14, 3, 1, 1, 32'h2,        32'h4};
        tv[10] = '{1, 0, 0, 1, 32'h0,        32'h0,  2, 1, 1, 32'h3,        32'h8};
        tv[11] = '{1, 0, 0, 1, 32'h0,        32'h0,  1, 1, 1, 32'h4,        32'hC};
        tv[12] = '{1, 0, 0, 1, 32'h0,        32'h0,  0, 0, 1, 32'h1,        32'h0};
        tv[13] = '{1, 0, 0, 1, 32'h0,        32'h0,  0, 0, 1, 32'h1,        32'h0};
        tv[14] = '{1, 0, 1, 0, 32'h08000010, 32'h40, 1, 1, 1, 32'h08000010, 32'h40};
        tv[15] = '{1, 0, 1, 1, 32'h00031080, 32'h44, 1, 1, 1, 32'h00031080, 32'h44};
        #1;
        for (int i = 0; i < 16; i++) begin
            step(tv[i].rstn, tv[i].flush, tv[i].push, tv[i].pop, tv[i].ins, tv[i].pc);
            chk($sformatf("v%0d count", i), 32'(bus.count), 32'(tv[i].cnt));
            chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(tv[i].ov));
            chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(tv[i].ir));
            chk($sformatf("v%0d out_ins", i), bus.out_ins, tv[i].hins);
            chk($sformatf("v%0d out_pc", i), bus.out_pc, tv[i].hpc);
        end
        // decode of lw, j and sll heads
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 32'h8C220004, 32'h0);
        chk("lw opCode", 32'(bus.opCode), 32'h23);
        chk("lw rs", 32'(bus.rs), 32'd1);
        chk("lw rt", 32'(bus.rt), 32'd2);
        chk("lw immediate", 32'(bus.immediate), 32'h0004);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 32'h08000010, 32'h0);
        chk("j opCode", 32'(bus.opCode), 32'h02);
        chk("j addr", 32'(bus.addr), 32'h0000010);
        step(1, 0, 1, 1, 32'h00031080, 32'h4);
        chk("sll opCode", 32'(bus.opCode), 32'h0);
        chk("sll rd", 32'(bus.rd), 32'd2);
        chk("sll rt", 32'(bus.rt), 32'd3);
        chk("sll sa", 32'(bus.sa), 32'd2);
        // simultaneous push and pop at count 2 across pointer wrap
        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            step(1, 0, 1, 0, 32'hA000_0000 + 32'(k), 32'h100 + 32'(4 * k));
            mq_ins.push_back(32'hA000_0000 + 32'(k));
            mq_pc.push_back(32'h100 + 32'(4 * k));
        end
        for (int k = 2; k < 12; k++) begin
            step(1, 0, 1, 1, 32'hA000_0000 + 32'(k), 32'h100 + 32'(4 * k));
            mq_ins.push_back(32'hA000_0000 + 32'(k));
            mq_pc.push_back(32'h100 + 32'(4 * k));
            void'(mq_ins.pop_front());
            void'(mq_pc.pop_front());
            chk($sformatf("wrap%0d count", k), 32'(bus.count), 32'd2);
            chk($sformatf("wrap%0d out_ins", k), bus.out_ins, mq_ins[0]);
            chk($sformatf("wrap%0d out_pc", k), bus.out_pc, mq_pc[0]);
        end
        // flush beats a concurrent push and pop
        step(1, 0, 1, 0, 32'hB0, 32'h0);
        chk("pre-flush count", 32'(bus.count), 32'd3);
        step(1, 1, 1, 1, 32'hB1, 32'h4);
        chk("flush count", 32'(bus.count), 32'd0);
        chk("flush out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush in_ready", 32'(bus.in_ready), 32'd1);
        step(1, 0, 1, 0, 32'h77, 32'h200);
        step(1, 0, 1, 0, 32'h78, 32'h204);
        chk("post-flush head", bus.out_ins, 32'h77);
        chk("post-flush pc", bus.out_pc, 32'h200);
        step(1, 0, 1, 0, 32'h79, 32'h208);
        chk("pre-reset count", 32'(bus.count), 32'd3);
        // reset overrides push and pop mid-operation
        step(0, 0, 1, 1, 32'hDEAD, 32'hBEEF);
        chk("reset count", 32'(bus.count), 32'd0);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_ins", bus.out_ins, 32'h0);
        chk("reset out_pc", bus.out_pc, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
